// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian signal controller.
// Lamp codes match the traffic_light_controller one-hot encoding.
package ped_pkg;

  typedef enum logic [1:0] {
    ST_DONT_WALK = 2'd0,
    ST_WALK      = 2'd1,
    ST_FLASH     = 2'd2,
    ST_FAULT     = 2'd3
  } ped_state_t;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  localparam int unsigned DEF_WALK_TIME    = 12;
  localparam int unsigned DEF_FLASH_TIME   = 10;
  localparam int unsigned DEF_FLASH_PERIOD = 2;

  function automatic logic lights_legal(input logic [2:0] code);
    return (code == LIGHT_GREEN) || (code == LIGHT_YELLOW) || (code == LIGHT_RED);
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser for the raw push-button plus a rising-edge detector.
// rise is high for one cycle, two edges after the raw input goes high.
module button_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK / DON'T WALK controller slaved to the vehicle lamp code.
// A WALK is only granted on the edge where red begins and a request is pending.
module ped_signal_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned WALK_TIME    = DEF_WALK_TIME,
  parameter int unsigned FLASH_TIME   = DEF_FLASH_TIME,
  parameter int unsigned FLASH_PERIOD = DEF_FLASH_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] lights,
  input  logic       ped_button,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_waiting,
  output logic       fault
);

  ped_state_t state, state_n;
  logic [5:0] cnt, cnt_n, cnt_inc;
  logic       flash_ph, flash_ph_n;
  logic       waiting, waiting_n;
  logic [2:0] prev_lights;
  logic       btn_rise;
  logic       is_red;
  logic       red_onset;
  logic       serve;

  button_sync u_button_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (ped_button),
    .rise     (btn_rise)
  );

  assign is_red    = (lights == LIGHT_RED);
  assign red_onset = is_red && (prev_lights != LIGHT_RED);
  assign serve     = waiting || btn_rise;
  assign cnt_inc   = cnt + 6'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_DONT_WALK;
      cnt         <= '0;
      flash_ph    <= 1'b0;
      waiting     <= 1'b0;
      prev_lights <= LIGHT_RED;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      flash_ph    <= flash_ph_n;
      waiting     <= waiting_n;
      prev_lights <= lights;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    flash_ph_n = flash_ph;
    waiting_n  = waiting | btn_rise;

    case (state)
      ST_DONT_WALK: begin
        if (red_onset && serve) begin
          state_n   = ST_WALK;
          cnt_n     = '0;
          waiting_n = btn_rise;
        end
      end
      ST_WALK: begin
        if (!is_red) begin
          state_n = ST_DONT_WALK;
          cnt_n   = '0;
        end else if (cnt == 6'(WALK_TIME - 1)) begin
          state_n    = ST_FLASH;
          cnt_n      = '0;
          flash_ph_n = 1'b0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_FLASH: begin
        // Losing red and timing out both end in DONT_WALK, so one branch covers both.
        if (!is_red || (cnt == 6'(FLASH_TIME - 1))) begin
          state_n    = ST_DONT_WALK;
          cnt_n      = '0;
          flash_ph_n = 1'b0;
        end else begin
          cnt_n = cnt_inc;
          if ((cnt_inc % 6'(FLASH_PERIOD)) == '0) begin
            flash_ph_n = ~flash_ph;
          end
        end
      end
      default: ;
    endcase

    if (!lights_legal(lights) || (state == ST_FAULT)) begin
      state_n    = ST_FAULT;
      cnt_n      = '0;
      flash_ph_n = 1'b0;
      waiting_n  = 1'b0;
    end
  end

  always_comb begin
    walk      = 1'b0;
    dont_walk = 1'b1;
    case (state)
      ST_WALK: begin
        walk      = 1'b1;
        dont_walk = 1'b0;
      end
      ST_FLASH: dont_walk = ~flash_ph;
      default: ;
    endcase
  end

  assign ped_waiting = waiting;
  assign fault       = (state == ST_FAULT);

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed self-checking bench for ped_signal_ctrl with default timing.
module tb_ped_signal_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] lights;
  logic       ped_button;
  logic       walk;
  logic       dont_walk;
  logic       ped_waiting;
  logic       fault;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [0:9] flash_exp;

  ped_signal_ctrl #(
    .WALK_TIME    (12),
    .FLASH_TIME   (10),
    .FLASH_PERIOD (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lights      (lights),
    .ped_button  (ped_button),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .ped_waiting (ped_waiting),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lamps(input logic exp_walk, input logic exp_dw, input string tag);
    chk({tag, ".walk"}, walk, exp_walk);
    chk({tag, ".dont_walk"}, dont_walk, exp_dw);
  endtask

  // Lamp exclusivity sampled every cycle on the falling edge.
  always @(negedge clk) begin
    if (reset === 1'b0) chk("exclusive", walk & dont_walk, 1'b0);
  end

  initial begin
    flash_exp  = 10'b1100110011;
    reset      = 1'b1;
    lights     = 3'b001;
    ped_button = 1'b0;
    tick(2);
    lamps(1'b0, 1'b1, "rst");
    chk("rst.ped_waiting", ped_waiting, 1'b0);
    chk("rst.fault", fault, 1'b0);
    reset = 1'b0;
    tick(1);

    // Served request: press in green, then yellow, then red onset.
    ped_button = 1'b1;
    tick(3);
    chk("t1.wait_green", ped_waiting, 1'b1);
    ped_button = 1'b0;
    lights = 3'b010;
    tick(2);
    chk("t1.wait_yellow", ped_waiting, 1'b1);
    lamps(1'b0, 1'b1, "t1.yellow");
    lights = 3'b100;
    tick(1);
    chk("t1.wait_served", ped_waiting, 1'b0);
    for (int i = 0; i < 12; i++) begin
      lamps(1'b1, 1'b0, "t1.walk");
      tick(1);
    end
    for (int i = 0; i < 10; i++) begin
      chk("t1.flash.walk", walk, 1'b0);
      chk("t1.flash.dont_walk", dont_walk, flash_exp[i]);
      tick(1);
    end
    for (int i = 0; i < 3; i++) begin
      lamps(1'b0, 1'b1, "t1.after");
      tick(1);
    end
    chk("t1.wait_after", ped_waiting, 1'b0);

    // Full red cycle with no request.
    lights = 3'b001;
    tick(2);
    lights = 3'b010;
    tick(2);
    lights = 3'b100;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      lamps(1'b0, 1'b1, "t2.red");
    end

    // Green intrudes at WALK cycle 5.
    lights = 3'b001;
    ped_button = 1'b1;
    tick(3);
    ped_button = 1'b0;
    lights = 3'b010;
    tick(2);
    lights = 3'b100;
    tick(1);
    lamps(1'b1, 1'b0, "t3.walk0");
    tick(5);
    lamps(1'b1, 1'b0, "t3.walk5");
    lights = 3'b001;
    tick(1);
    lamps(1'b0, 1'b1, "t3.abort");
    lights = 3'b010;
    tick(2);
    lights = 3'b100;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      lamps(1'b0, 1'b1, "t3.no_walk");
    end

    // Press during FLASH cycle 3, carried to the next red onset.
    lights = 3'b001;
    ped_button = 1'b1;
    tick(3);
    ped_button = 1'b0;
    lights = 3'b010;
    tick(2);
    lights = 3'b100;
    tick(1);
    lamps(1'b1, 1'b0, "t4.walk");
    tick(12);
    chk("t4.flash0", dont_walk, 1'b1);
    tick(3);
    ped_button = 1'b1;
    tick(3);
    chk("t4.wait_flash", ped_waiting, 1'b1);
    chk("t4.flash6.walk", walk, 1'b0);
    ped_button = 1'b0;
    tick(4);
    lamps(1'b0, 1'b1, "t4.dw");
    chk("t4.wait_dw", ped_waiting, 1'b1);
    lights = 3'b001;
    tick(3);
    chk("t4.wait_green", ped_waiting, 1'b1);
    lights = 3'b010;
    tick(2);
    chk("t4.wait_yellow", ped_waiting, 1'b1);
    lights = 3'b100;
    tick(1);
    lamps(1'b1, 1'b0, "t4.served");
    chk("t4.wait_cleared", ped_waiting, 1'b0);

    // Reset pulse at WALK cycle 4 with red held through release.
    tick(4);
    lamps(1'b1, 1'b0, "t5.walk4");
    reset = 1'b1;
    #1;
    lamps(1'b0, 1'b1, "t5.async");
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      lamps(1'b0, 1'b1, "t5.red_at_release");
    end

    // Illegal code locks into fault.
    lights = 3'b001;
    tick(2);
    lights = 3'b011;
    tick(1);
    chk("t6.fault", fault, 1'b1);
    lamps(1'b0, 1'b1, "t6.fault");
    lights = 3'b001;
    ped_button = 1'b1;
    tick(3);
    ped_button = 1'b0;
    chk("t6.wait_ignored", ped_waiting, 1'b0);
    lights = 3'b010;
    tick(2);
    lights = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      lamps(1'b0, 1'b1, "t6.no_walk");
      chk("t6.fault_held", fault, 1'b1);
    end
    reset = 1'b1;
    #1;
    chk("t6.fault_cleared", fault, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("t6.fault_after", fault, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
